// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: turns one endpoint pair into a stream of clipped
// per-pixel frame-store writes with valid/ready backpressure.
module line_rasterizer #(
  parameter int WIDTH   = 480,
  parameter int HEIGHT  = 272,
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int COLOR_W = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [X_W-1:0]     x0,
  input  logic [X_W-1:0]     x1,
  input  logic [Y_W-1:0]     y0,
  input  logic [Y_W-1:0]     y1,
  input  logic [COLOR_W-1:0] color,
  output logic               busy,
  output logic               done,
  output logic               pvalid,
  input  logic               pready,
  output logic [X_W-1:0]     px,
  output logic [Y_W-1:0]     py,
  output logic [COLOR_W-1:0] pcolor
);

  localparam int ERR_W = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam logic [X_W:0]   L_WIDTH  = (X_W+1)'(WIDTH);
  localparam logic [Y_W:0]   L_HEIGHT = (Y_W+1)'(HEIGHT);
  localparam logic [X_W-1:0] X_ONE    = X_W'(1);
  localparam logic [Y_W-1:0] Y_ONE    = Y_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_t;

  state_t                    r_state;
  logic [X_W-1:0]            r_x0, r_x1, r_cx;
  logic [Y_W-1:0]            r_y0, r_y1, r_cy;
  logic [COLOR_W-1:0]        r_color;
  logic signed [ERR_W-1:0]   r_dx, r_dy, r_err;
  logic                      r_sx_neg, r_sy_neg;
  logic                      r_busy, r_done, r_pvalid;

  logic [X_W-1:0]            w_adx, w_nx;
  logic [Y_W-1:0]            w_ady, w_ny;
  logic signed [ERR_W-1:0]   w_dx_init, w_dy_init, w_e2, w_err_n;
  logic                      w_stepx, w_stepy, w_last, w_retire;
  logic                      w_vis_init, w_vis_next;

  assign w_adx     = (r_x1 >= r_x0) ? (r_x1 - r_x0) : (r_x0 - r_x1);
  assign w_ady     = (r_y1 >= r_y0) ? (r_y1 - r_y0) : (r_y0 - r_y1);
  assign w_dx_init = $signed({{(ERR_W-X_W){1'b0}}, w_adx});
  assign w_dy_init = -$signed({{(ERR_W-Y_W){1'b0}}, w_ady});

  // Both axis decisions are taken from the pre-step error term.
  assign w_e2    = r_err <<< 1;
  assign w_stepx = (w_e2 >= r_dy);
  assign w_stepy = (w_e2 <= r_dx);
  assign w_err_n = r_err + (w_stepx ? r_dy : '0) + (w_stepy ? r_dx : '0);
  assign w_nx    = w_stepx ? (r_sx_neg ? r_cx - X_ONE : r_cx + X_ONE) : r_cx;
  assign w_ny    = w_stepy ? (r_sy_neg ? r_cy - Y_ONE : r_cy + Y_ONE) : r_cy;

  assign w_last     = (r_cx == r_x1) && (r_cy == r_y1);
  assign w_retire   = (r_state == S_DRAW) && (!r_pvalid || pready);
  assign w_vis_init = ({1'b0, r_x0} < L_WIDTH) && ({1'b0, r_y0} < L_HEIGHT);
  assign w_vis_next = ({1'b0, w_nx} < L_WIDTH) && ({1'b0, w_ny} < L_HEIGHT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_x0     <= '0;
      r_x1     <= '0;
      r_y0     <= '0;
      r_y1     <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_color  <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_err    <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pvalid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x0    <= x0;
            r_x1    <= x1;
            r_y0    <= y0;
            r_y1    <= y1;
            r_color <= color;
            r_busy  <= 1'b1;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_dx     <= w_dx_init;
          r_dy     <= w_dy_init;
          r_err    <= w_dx_init + w_dy_init;
          r_sx_neg <= !(r_x0 < r_x1);
          r_sy_neg <= !(r_y0 < r_y1);
          r_cx     <= r_x0;
          r_cy     <= r_y0;
          r_pvalid <= w_vis_init;
          r_state  <= S_DRAW;
        end
        S_DRAW: begin
          if (w_retire) begin
            if (w_last) begin
              r_pvalid <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_err    <= w_err_n;
              r_cx     <= w_nx;
              r_cy     <= w_ny;
              r_pvalid <= w_vis_next;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign pvalid = r_pvalid;
  assign px     = r_cx;
  assign py     = r_cy;
  assign pcolor = r_color;

endmodule
